// File: rtl/div_seq_unit.sv
// Multicycle signed divider: restoring division on operand magnitudes, one
// quotient bit per cycle, then a sign-fix cycle; start/done handshake to the control unit.
module div_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1).
    always_comb begin
        trial = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
        abs_a = a[WIDTH-1] ? -a : a;
        abs_b = b[WIDTH-1] ? -b : b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (b == '0) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            sign_r <= a[WIDTH-1];
                            dvd    <= abs_a;
                            dvs    <= abs_b;
                            rem    <= '0;
                            cnt    <= CNT_LAST;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // dvd doubles as the quotient register: bits shift in at the LSB.
                    if (trial[WIDTH]) begin
                        rem <= {rem[WIDTH-2:0], dvd[WIDTH-1]};
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    lo    <= sign_q ? -dvd : dvd;
                    hi    <= sign_r ? -rem : rem;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_unit.sv
// Bench for div_seq_unit: directed cases plus random operands checked against
// an arithmetic reference (signed divide truncating toward zero).
module tb_div_seq_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    div_seq_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: 64-bit signed arithmetic, results truncated to 32 bits.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q = 32'(sx / sy);
        r = 32'(sx % sy);
    endfunction

    // One operation; optional extra start pulse at edge count pulse_at and/or in the done cycle.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input int pulse_at, input bit pulse_done);
        int   lat;
        bit   busy_ok;
        bit   zero;
        logic [31:0] q;
        logic [31:0] r;
        zero = (tb_v == 32'd0);
        if (!zero) begin
            model(ta, tb_v, q, r);
            exp_lo = q;
            exp_hi = r;
        end
        @(negedge clock);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == pulse_at) begin
                start = 1'b1;
                a = 32'd9;
                b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), zero ? 32'd0 : 32'd33);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_run"}, {31'd0, busy_ok & busy}, 32'd1);
        chk({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, zero});
        chk({tag, ".lo"}, lo, exp_lo);
        chk({tag, ".hi"}, hi, exp_hi);
        if (pulse_done) begin
            start = 1'b1;
            a = 32'd9;
            b = 32'd3;
        end
        @(negedge clock);
        start = 1'b0;
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ".dz_pulse"}, {31'd0, div_zero}, 32'd0);
        chk({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, ".lo_hold"}, lo, exp_lo);
        chk({tag, ".hi_hold"}, hi, exp_hi);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        bit seen;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.dz", {31'd0, div_zero}, 32'd0);
        chk("reset.hi", hi, 32'd0);
        chk("reset.lo", lo, 32'd0);

        run_op("7/2", 32'd7, 32'd2, -1, 1'b0);
        chk("7/2.lo_const", lo, 32'd3);
        chk("7/2.hi_const", hi, 32'd1);
        run_op("-7/2", 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        chk("-7/2.lo_const", lo, 32'hFFFF_FFFD);
        chk("-7/2.hi_const", hi, 32'hFFFF_FFFF);
        run_op("7/-2", 32'd7, 32'hFFFF_FFFE, -1, 1'b0);
        chk("7/-2.lo_const", lo, 32'hFFFF_FFFD);
        chk("7/-2.hi_const", hi, 32'd1);
        run_op("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, -1, 1'b0);
        chk("-7/-2.lo_const", lo, 32'd3);
        chk("-7/-2.hi_const", hi, 32'hFFFF_FFFF);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        chk("ovf.lo_const", lo, 32'h8000_0000);
        chk("ovf.hi_const", hi, 32'd0);
        run_op("0/5", 32'd0, 32'd5, -1, 1'b0);
        run_op("100/7", 32'd100, 32'd7, -1, 1'b0);
        run_op("123/0", 32'd123, 32'd0, -1, 1'b0);
        chk("123/0.lo_const", lo, 32'd14);
        chk("123/0.hi_const", hi, 32'd2);

        run_op("1000/3.ign", 32'd1000, 32'd3, 10, 1'b1);
        chk("1000/3.lo_const", lo, 32'd333);
        chk("1000/3.hi_const", hi, 32'd1);
        run_op("9/3", 32'd9, 32'd3, -1, 1'b0);

        // Reset in the middle of an operation abandons it.
        @(negedge clock);
        a = 32'd1000;
        b = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk("midrst.hi", hi, 32'd0);
        chk("midrst.lo", lo, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) seen = 1'b1;
        end
        chk("midrst.no_done", {31'd0, seen}, 32'd0);
        run_op("50/7", 32'd50, 32'd7, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            case (i % 4)
                1: y = 32'($urandom_range(1, 9));
                2: y = -32'($urandom_range(1, 9));
                3: x = 32'($urandom_range(0, 200)) - 32'd100;
                default: ;
            endcase
            if (i == 13) y = 32'd0;
            if (i == 17) x = 32'h8000_0000;
            run_op("rand", x, y, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_seq_unit.md
# div_seq_unit

Multicycle signed divider that answers the CPU control unit's divide request. It implements the responder side of the start/done handshake used for `div`/`divu`-class operations. Operands come from the A/B register path; the block delivers quotient and remainder to the HI/LO load path. It also flags division by zero so the control unit can take the exception path. One quotient bit is produced per cycle with restoring division on magnitudes, followed by a sign-fix cycle.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  dividend (two's complement), sampled with start
- b  in  WIDTH  divisor (two's complement), sampled with start
- busy  out  1  high from the edge accepting start until done drops
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse, coincident with done, when b == 0
- hi  out  WIDTH  remainder; holds until next successful completion
- lo  out  WIDTH  quotient; holds until next successful completion

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1, b≠0:
  - Capture sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
  - Load dvd = |a| and dvs = |b| (unsigned WIDTH bits, so |−2^(WIDTH−1)| = 2^(WIDTH−1)).
  - Clear rem, set cnt = WIDTH−1, busy=1, go to RUN.
- IDLE, start=1, b=0:
  - Go to DONE with div_zero=1.
  - hi/lo unchanged; no iteration.
- RUN, each cycle:
  - trial = {rem, dvd[MSB]} − dvs, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem = trial, quotient bit = 1.
  - Otherwise: rem = {rem, dvd[MSB]} truncated, quotient bit = 0.
  - dvd shifts left with the quotient bit entering at the LSB.
  - When cnt = 0, go to FIX; otherwise cnt−1.
- FIX:
  - lo = sign_q ? −q : q.
  - hi = sign_r ? −rem : rem.
  - Both truncated to WIDTH. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy stays 1.
  - Next state is IDLE.
- start is ignored outside IDLE, including in DONE.
- Overflow case −2^(WIDTH−1) / −1 is not flagged: lo = 0x80000000, hi = 0.
- Reset (any state, including mid-RUN):
  - Next edge forces IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0, internal registers cleared.
  - The operation in progress is abandoned.

## Timing
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0.
- start sampled at edge E0 (IDLE):
  - RUN occupies edges E1..E_WIDTH.
  - FIX at edge E_WIDTH+1 writes hi/lo.
  - done is high in the cycle after edge E_WIDTH+1. For WIDTH=32, done appears 33 edges after E0.
  - hi/lo are valid in the same cycle as done and remain stable afterwards.
- Divide by zero: done and div_zero are high in the cycle right after E0 (1-cycle latency).
- busy rises in the cycle after E0 and falls in the cycle after done.
- Back-to-back operation: the earliest new start is accepted on the edge when the state is IDLE, i.e. the cycle after done.
- a and b may change freely after E0.
- No combinational path from inputs to outputs; every output is registered.

## Test plan
- a=7, b=2, start one cycle -> done exactly 33 edges later, lo=3, hi=1, div_zero=0; busy high throughout; done high exactly one cycle.
- a=−7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then a=7, b=−2 -> lo=0xFFFFFFFD, hi=1; then a=−7, b=−2 -> lo=3, hi=0xFFFFFFFF.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; also a=0, b=5 -> lo=0, hi=0.
- Complete 100/7 (lo=14, hi=2), then a=123, b=0 -> next cycle done=1 and div_zero=1; hi=2 and lo=14 unchanged; busy low after one cycle.
- Start 1000/3, pulse start again with a=9, b=3 at cycle 10 and in the DONE cycle -> both ignored; result lo=333, hi=1; a fresh start right after done gives lo=3, hi=0.
- Start 1000/3, assert reset at cycle 15 -> next edge busy=0, hi=lo=0, and no done pulse ever appears; a following 50/7 completes normally with lo=7, hi=1.
